ppi_rw_control: RTL and testbench
=================================

Name: ppi_rw_control

Overview:
- Read/write control stage of the PPI, directly downstream of the data bus buffer.
- Samples the asynchronous host strobes (CS_n, RD_n, WR_n, A[1:0]) and captures bytes from the buffer's internal-bus output.
- On the WR_n rising edge it commits the byte as one of: a port write, a mode-set control word, or a bit set/reset command.
- Generates the buffer direction signal that lets internal read data drive PD.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the strobe/address synchronisers (legal 2..4).
- CW_RESET, 8'h9B, control word value loaded at reset (all ports input, mode 0).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- CS_n  input  1  chip select, active low, asynchronous.
- RD_n  input  1  read strobe, active low, asynchronous.
- WR_n  input  1  write strobe, active low, asynchronous.
- A  input  2  port/control address.
- DIN  input  8  byte from the data bus buffer (PD as seen internally).
- bus_drive  output  1  buffer direction; 1 = internal read data drives PD, 0 = PD floats.
- rd_sel  output  2  port selected for the read mux; valid while bus_drive=1.
- wr_data  output  8  last committed byte.
- port_wr  output  3  one-hot one-cycle write strobe for ports A/B/C.
- ctrl_word  output  8  current mode control word.
- mode_set  output  1  one-cycle pulse on a control-word load.
- bsr_pulse  output  1  one-cycle pulse on a bit set/reset command.
- bsr_bit  output  3  port C bit index for the BSR command.
- bsr_val  output  1  value to write to that bit.
- bus_err  output  1  sticky flag: RD_n and WR_n were sampled low together; cleared by reset only.

Behaviour:
- Reset (async, rst_n=0):
  - ctrl_word=CW_RESET; all other outputs 0.
  - Synchronisers load 1 for strobes and 0 for address; FSM goes to IDLE.
- Synchronisation: CS_n, RD_n, WR_n and A pass through SYNC_STAGES flops. Decode uses only the synchronised copies (cs, rd, wr, a).
- FSM states: IDLE, WRITE, READ, ERROR.
- IDLE:
  - cs & wr & !rd -> WRITE.
  - cs & rd & !wr -> READ.
  - cs & rd & wr -> ERROR.
- WRITE:
  - Each cycle, capture a and DIN into holding registers.
  - On wr deassert with cs still active: commit and return to IDLE.
  - cs deasserts first: abort with no commit, go to IDLE.
  - rd asserts: go to ERROR with no commit.
- Commit, in the cycle after the FSM sees wr deassert (all strobes one cycle wide):
  - Latency from the WR_n pin rising edge is SYNC_STAGES+1 clocks.
  - Addr 0/1/2: port_wr[addr]=1; wr_data=held byte.
  - Addr 3, D7=1: ctrl_word=byte; mode_set=1.
  - Addr 3, D7=0: bsr_pulse=1; bsr_bit=D[3:1]; bsr_val=D0; ctrl_word unchanged.
  - wr_data updates on every commit.
- READ:
  - bus_drive=1 and rd_sel=a while cs & rd & !wr, for addr 0..2.
  - Addr 3 (without the optional feature): bus_drive stays 0.
  - Exit to IDLE when rd or cs deasserts; bus_drive drops in that same cycle (registered output).
  - wr asserts: go to ERROR.
- ERROR:
  - bus_drive=0; bus_err=1.
  - Stay until cs, rd and wr are all inactive, then go to IDLE.
- bus_drive never asserts in WRITE or ERROR; the buffer is never driven while the host writes.
- A new transaction needs a return through IDLE; back-to-back strobes with one idle synchronised cycle are legal.

Optional Feature:
- Macro: PPI_CTRL_READBACK_EN.
- Defined: a read at addr 3 asserts bus_drive with rd_sel=3, so the downstream mux returns ctrl_word.
- Undefined: an addr 3 read leaves bus_drive=0; PD floats.

Test Plan:
- Reset: rst_n low mid-write -> ctrl_word=8'h9B, bus_drive=0, no pulse; after release an aborted write leaves no commit.
- Port write: CS_n=0, A=1, DIN=8'h5A, WR_n low 4 clk then high -> port_wr=3'b010 for exactly 1 clk, SYNC_STAGES+1 clk after the WR_n rise; wr_data=8'h5A.
- Mode set and BSR:
  - A=3, DIN=8'h80 write -> mode_set pulse; ctrl_word=8'h80.
  - Then A=3, DIN=8'h0B -> bsr_pulse; bsr_bit=5; bsr_val=1; ctrl_word still 8'h80.
- Read: A=2, RD_n low 5 clk -> bus_drive=1, rd_sel=2 after the sync delay; bus_drive=0 within SYNC_STAGES+1 clk of the RD_n rise. Repeat at A=3 -> bus_drive=0 (=1, rd_sel=3 with PPI_CTRL_READBACK_EN).
- Conflict: RD_n and WR_n low together -> bus_err=1, bus_drive=0, no commit; the next clean write still commits.
- Abort: CS_n high before WR_n rises -> no port_wr/mode_set/bsr_pulse; ctrl_word unchanged.

Source files
------------

// File: rtl/ppi_rw_control.sv
// PPI read/write control: synchronises host strobes, decodes port/control writes, drives buffer direction.
// Optional macro PPI_CTRL_READBACK_EN: an addr-3 read drives the control word back onto PD.
module ppi_rw_control #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CW_RESET    = 8'h9B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  output logic       bus_drive,
  output logic [1:0] rd_sel,
  output logic [7:0] wr_data,
  output logic [2:0] port_wr,
  output logic [7:0] ctrl_word,
  output logic       mode_set,
  output logic       bsr_pulse,
  output logic [2:0] bsr_bit,
  output logic       bsr_val,
  output logic       bus_err
);

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE, WRITE, READ, ERROR} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0]         cs_n_sr, rd_n_sr, wr_n_sr;
  logic [SYNC_STAGES-1:0][AW-1:0] a_sr;
  logic                           cs, rd, wr;
  logic [AW-1:0]                  a;

  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  logic          hold_en;
  logic          commit;
  logic          addr_ok;

  logic          bus_drive_d;
  logic [1:0]    rd_sel_d;
  logic [DW-1:0] wr_data_d;
  logic [2:0]    port_wr_d;
  logic [DW-1:0] ctrl_word_d;
  logic          mode_set_d;
  logic          bsr_pulse_d;
  logic [2:0]    bsr_bit_d;
  logic          bsr_val_d;
  logic          bus_err_d;

  // Strobe/address synchronisers; strobes idle high, address idles at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_sr <= '1;
      rd_n_sr <= '1;
      wr_n_sr <= '1;
      a_sr    <= '0;
    end else begin
      cs_n_sr <= {cs_n_sr[SYNC_STAGES-2:0], CS_n};
      rd_n_sr <= {rd_n_sr[SYNC_STAGES-2:0], RD_n};
      wr_n_sr <= {wr_n_sr[SYNC_STAGES-2:0], WR_n};
      a_sr    <= {a_sr[SYNC_STAGES-2:0], A};
    end
  end

  assign cs = ~cs_n_sr[SYNC_STAGES-1];
  assign rd = ~rd_n_sr[SYNC_STAGES-1];
  assign wr = ~wr_n_sr[SYNC_STAGES-1];
  assign a  = a_sr[SYNC_STAGES-1];

`ifdef PPI_CTRL_READBACK_EN
  assign addr_ok = 1'b1;
`else
  assign addr_ok = (a != 2'd3);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d     = state_q;
    commit      = 1'b0;
    bus_drive_d = 1'b0;
    rd_sel_d    = rd_sel;
    wr_data_d   = wr_data;
    port_wr_d   = 3'b000;
    ctrl_word_d = ctrl_word;
    mode_set_d  = 1'b0;
    bsr_pulse_d = 1'b0;
    bsr_bit_d   = bsr_bit;
    bsr_val_d   = bsr_val;

    unique case (state_q)
      IDLE: begin
        if (cs && rd && wr)  state_d = ERROR;
        else if (cs && wr)   state_d = WRITE;
        else if (cs && rd)   state_d = READ;
      end
      WRITE: begin
        if (rd)              state_d = ERROR;
        else if (!cs)        state_d = IDLE;
        else if (!wr) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      READ: begin
        if (wr)              state_d = ERROR;
        else if (!cs || !rd) state_d = IDLE;
      end
      ERROR: begin
        if (!cs && !rd && !wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Capture on entry as well so a one-cycle write still holds a byte
    hold_en = (state_d == WRITE);

    if (commit) begin
      wr_data_d = hold_data;
      if (hold_addr != 2'd3) begin
        port_wr_d = 3'b001 << hold_addr;
      end else if (hold_data[7]) begin
        ctrl_word_d = hold_data;
        mode_set_d  = 1'b1;
      end else begin
        bsr_pulse_d = 1'b1;
        bsr_bit_d   = hold_data[3:1];
        bsr_val_d   = hold_data[0];
      end
    end

    if (state_d == READ && addr_ok) begin
      bus_drive_d = 1'b1;
      rd_sel_d    = a;
    end

    bus_err_d = bus_err | (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (hold_en) begin
      hold_addr <= a;
      hold_data <= DIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_drive <= 1'b0;
      rd_sel    <= '0;
      wr_data   <= '0;
      port_wr   <= '0;
      ctrl_word <= CW_RESET;
      mode_set  <= 1'b0;
      bsr_pulse <= 1'b0;
      bsr_bit   <= '0;
      bsr_val   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      bus_drive <= bus_drive_d;
      rd_sel    <= rd_sel_d;
      wr_data   <= wr_data_d;
      port_wr   <= port_wr_d;
      ctrl_word <= ctrl_word_d;
      mode_set  <= mode_set_d;
      bsr_pulse <= bsr_pulse_d;
      bsr_bit   <= bsr_bit_d;
      bsr_val   <= bsr_val_d;
      bus_err   <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_ppi_rw_control.sv
// Self-checking bench for ppi_rw_control: directed scenarios plus randomized writes/reads against a transaction model.
module tb_ppi_rw_control;

  localparam int unsigned S = 2;

  logic       clk, rst_n;
  logic       CS_n, RD_n, WR_n;
  logic [1:0] A;
  logic [7:0] DIN;
  logic       bus_drive;
  logic [1:0] rd_sel;
  logic [7:0] wr_data;
  logic [2:0] port_wr;
  logic [7:0] ctrl_word;
  logic       mode_set, bsr_pulse;
  logic [2:0] bsr_bit;
  logic       bsr_val, bus_err;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Transaction-level model state
  logic [7:0] m_ctrl;
  logic [7:0] m_wr_data;
  logic [2:0] m_bsr_bit;
  logic       m_bsr_val;
  logic       m_err;

  ppi_rw_control #(.SYNC_STAGES(S), .CW_RESET(8'h9B)) dut (
    .clk(clk), .rst_n(rst_n), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A), .DIN(DIN),
    .bus_drive(bus_drive), .rd_sel(rd_sel), .wr_data(wr_data), .port_wr(port_wr),
    .ctrl_word(ctrl_word), .mode_set(mode_set), .bsr_pulse(bsr_pulse),
    .bsr_bit(bsr_bit), .bsr_val(bsr_val), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (|port_wr || mode_set || bsr_pulse) pulse_cnt++;

  function automatic logic readable(input logic [1:0] addr);
`ifdef PPI_CTRL_READBACK_EN
    return 1'b1;
`else
    return addr != 2'd3;
`endif
  endfunction

  function automatic void model_reset();
    m_ctrl = 8'h9B; m_wr_data = 8'h00; m_bsr_bit = 3'd0; m_bsr_val = 1'b0; m_err = 1'b0;
  endfunction

  task automatic do_write(input logic [1:0] addr, input logic [7:0] data, input int gap, input string tag);
    logic [2:0] exp_pw;
    logic       exp_ms, exp_bsr, bd_seen;
    int         hits, hit_k;
    exp_pw  = (addr != 2'd3) ? 3'(1 << addr) : 3'b000;
    exp_ms  = (addr == 2'd3) && data[7];
    exp_bsr = (addr == 2'd3) && !data[7];
    bd_seen = 1'b0;
    @(negedge clk); CS_n = 1'b0; A = addr; DIN = data; WR_n = 1'b0;
    repeat (4) @(negedge clk);
    WR_n = 1'b1;
    hits = 0; hit_k = -1;
    for (int k = 1; k <= int'(S) + 3; k++) begin
      @(posedge clk); #1;
      bd_seen |= bus_drive;
      if (|port_wr || mode_set || bsr_pulse) begin
        hits++;
        if (hit_k < 0) hit_k = k;
        checks++;
        if (port_wr !== exp_pw || mode_set !== exp_ms || bsr_pulse !== exp_bsr) begin
          errors++;
          $display("FAIL %s pulse: port_wr=%b mode_set=%b bsr_pulse=%b expected %b %b %b",
                   tag, port_wr, mode_set, bsr_pulse, exp_pw, exp_ms, exp_bsr);
        end
      end
    end
    checks++;
    if (hits != 1 || hit_k != int'(S) + 1) begin
      errors++;
      $display("FAIL %s timing: %0d pulse cycles, first at %0d; expected 1 at %0d", tag, hits, hit_k, S + 1);
    end
    m_wr_data = data;
    if (exp_ms) m_ctrl = data;
    if (exp_bsr) begin m_bsr_bit = data[3:1]; m_bsr_val = data[0]; end
    checks++;
    if (wr_data !== m_wr_data || ctrl_word !== m_ctrl || bsr_bit !== m_bsr_bit ||
        bsr_val !== m_bsr_val || bus_err !== m_err || bd_seen !== 1'b0) begin
      errors++;
      $display("FAIL %s state: wr_data=%h ctrl=%h bit=%0d val=%b err=%b bd=%b expected %h %h %0d %b %b 0",
               tag, wr_data, ctrl_word, bsr_bit, bsr_val, bus_err, bd_seen,
               m_wr_data, m_ctrl, m_bsr_bit, m_bsr_val, m_err);
    end
    @(negedge clk); CS_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] addr, input string tag);
    logic exp_bd;
    exp_bd = readable(addr);
    @(negedge clk); CS_n = 1'b0; A = addr; RD_n = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == int'(S)) begin
        checks++;
        if (bus_drive !== 1'b0) begin
          errors++; $display("FAIL %s early: bus_drive=%b expected 0", tag, bus_drive);
        end
      end
      if (k >= int'(S) + 1) begin
        checks++;
        if (bus_drive !== exp_bd || (exp_bd && rd_sel !== addr)) begin
          errors++;
          $display("FAIL %s drive k=%0d: bus_drive=%b rd_sel=%0d expected %b %0d", tag, k, bus_drive, rd_sel, exp_bd, addr);
        end
      end
    end
    @(negedge clk); RD_n = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1;
    checks++;
    if (bus_drive !== 1'b0) begin
      errors++; $display("FAIL %s release: bus_drive=%b expected 0", tag, bus_drive);
    end
    @(negedge clk); CS_n = 1'b1;
    repeat (S + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    int p0;
    rst_n = 1'b0; CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; A = 2'd0; DIN = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ctrl_word !== 8'h9B || bus_drive !== 1'b0 || port_wr !== 3'b000 || mode_set !== 1'b0 ||
        bsr_pulse !== 1'b0 || wr_data !== 8'h00 || bus_err !== 1'b0 || rd_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: ctrl=%h bd=%b pw=%b ms=%b bsr=%b wd=%h err=%b",
               ctrl_word, bus_drive, port_wr, mode_set, bsr_pulse, wr_data, bus_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    p0 = pulse_cnt;
    CS_n = 1'b0; A = 2'd3; DIN = 8'h80; WR_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl_word !== 8'h9B || bus_drive !== 1'b0 || pulse_cnt != p0) begin
      errors++;
      $display("FAIL reset_midwrite: ctrl=%h bd=%b pulses=%0d expected 9b 0 %0d", ctrl_word, bus_drive, pulse_cnt, p0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    CS_n = 1'b1;
    repeat (S + 3) @(negedge clk);
    WR_n = 1'b1;
    repeat (S + 3) @(negedge clk);
    checks++;
    if (pulse_cnt != p0 || ctrl_word !== 8'h9B || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_abort: pulses=%0d ctrl=%h wd=%h expected %0d 9b 00", pulse_cnt, ctrl_word, wr_data, p0);
    end
  endtask

  task automatic test_port_write();
    do_write(2'd1, 8'h5A, S + 2, "port_write_b");
    checks++;
    if (wr_data !== 8'h5A) begin
      errors++; $display("FAIL port_write_data: wr_data=%h expected 5a", wr_data);
    end
  endtask

  task automatic test_mode_bsr();
    do_write(2'd3, 8'h80, S + 2, "mode_set");
    checks++;
    if (ctrl_word !== 8'h80) begin
      errors++; $display("FAIL mode_set_cw: ctrl=%h expected 80", ctrl_word);
    end
    do_write(2'd3, 8'h0B, S + 2, "bsr");
    checks++;
    if (bsr_bit !== 3'd5 || bsr_val !== 1'b1 || ctrl_word !== 8'h80) begin
      errors++; $display("FAIL bsr_fields: bit=%0d val=%b ctrl=%h expected 5 1 80", bsr_bit, bsr_val, ctrl_word);
    end
  endtask

  task automatic test_read();
    do_read(2'd2, "read_c");
    do_read(2'd3, "read_ctrl");
    do_read(2'd0, "read_a");
  endtask

  task automatic test_conflict();
    int   p0;
    logic bd_seen;
    p0 = pulse_cnt; bd_seen = 1'b0;
    @(negedge clk); CS_n = 1'b0; A = 2'd1; DIN = 8'hC3; RD_n = 1'b0; WR_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1; bd_seen |= bus_drive;
    end
    checks++;
    if (bus_err !== 1'b1) begin
      errors++; $display("FAIL conflict_err: bus_err=%b expected 1", bus_err);
    end
    @(negedge clk); RD_n = 1'b1; WR_n = 1'b1; CS_n = 1'b1;
    for (int k = 1; k <= int'(S) + 3; k++) begin
      @(posedge clk); #1; bd_seen |= bus_drive;
    end
    m_err = 1'b1;
    checks++;
    if (bd_seen !== 1'b0 || pulse_cnt != p0 || wr_data !== m_wr_data || bus_err !== 1'b1) begin
      errors++;
      $display("FAIL conflict_nocommit: bd=%b pulses=%0d wd=%h err=%b expected 0 %0d %h 1",
               bd_seen, pulse_cnt, wr_data, bus_err, p0, m_wr_data);
    end
    do_write(2'd2, 8'hA5, S + 2, "post_conflict");
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulse_cnt;
    @(negedge clk); CS_n = 1'b0; A = 2'd3; DIN = 8'h91; WR_n = 1'b0;
    repeat (4) @(negedge clk);
    CS_n = 1'b1;
    repeat (S + 3) @(negedge clk);
    WR_n = 1'b1;
    repeat (S + 3) @(negedge clk);
    checks++;
    if (pulse_cnt != p0 || ctrl_word !== m_ctrl || wr_data !== m_wr_data) begin
      errors++;
      $display("FAIL abort: pulses=%0d ctrl=%h wd=%h expected %0d %h %h", pulse_cnt, ctrl_word, wr_data, p0, m_ctrl, m_wr_data);
    end
  endtask

  task automatic test_back_to_back();
    do_write(2'd0, 8'h11, 1, "b2b_0");
    do_write(2'd3, 8'h07, 1, "b2b_1");
    do_write(2'd2, 8'hEE, S + 2, "b2b_2");
  endtask

  task automatic test_random();
    logic [1:0] addr;
    logic [7:0] data;
    for (int i = 0; i < 24; i++) begin
      addr = 2'($urandom_range(0, 3));
      data = 8'($urandom);
      if ($urandom_range(0, 2) == 0) do_read(addr, "rand_read");
      else do_write(addr, data, int'($urandom_range(1, 4)), "rand_write");
    end
  endtask

  initial begin
    test_reset();
    test_port_write();
    test_mode_bsr();
    test_read();
    test_conflict();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
